// File: rtl/regfile_access_engine.sv
// regfile_access_engine: fills a register-file range from a word stream or dumps
// it as an address/data stream, owning the write port and first read port.
module regfile_access_engine #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_mode,
   input  logic [ADDR_W-1:0] cmd_first,
   input  logic [ADDR_W-1:0] cmd_last,
   input  logic              cmd_abort,
   output logic              rf_enable_write,
   output logic [ADDR_W-1:0] rf_write_address,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [ADDR_W-1:0] rf_read_address,
   input  logic [DATA_W-1:0] rf_read_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam logic [1:0] IDLE = 2'd0, DUMP_RD = 2'd1, DUMP_WAIT = 2'd2, FILL = 2'd3;
   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr, last;
   assign cmd_ready        = state == IDLE;
   assign busy             = state != IDLE;
   assign in_ready         = state == FILL;
   assign rf_enable_write  = in_valid & in_ready;
   assign rf_write_address = ptr;
   assign rf_write_data    = in_ready ? in_data : '0;
   assign rf_read_address  = ptr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         last      <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // abort wins over any state action; a same-cycle fill write still lands
         if (state != IDLE && cmd_abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: if (cmd_valid) begin
                  if (cmd_first > cmd_last) err <= 1'b1;
                  else begin
                     ptr   <= cmd_first;
                     last  <= cmd_last;
                     state <= cmd_mode ? FILL : DUMP_RD;
                  end
               end
               DUMP_RD: begin
                  out_addr  <= ptr;
                  out_data  <= rf_read_data;
                  out_valid <= 1'b1;
                  state     <= DUMP_WAIT;
               end
               DUMP_WAIT: if (out_ready) begin
                  out_valid <= 1'b0;
                  done      <= ptr == last;
                  state     <= ptr == last ? IDLE : DUMP_RD;
                  ptr       <= ptr == last ? ptr : ptr + 1'b1;
               end
               FILL: if (in_valid) begin
                  done  <= ptr == last;
                  state <= ptr == last ? IDLE : FILL;
                  ptr   <= ptr == last ? ptr : ptr + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_regfile_access_engine.sv
// tb_regfile_access_engine: directed fill/dump/abort/reset vectors against a
// behavioural register file, with hand-written expected words.
module tb_regfile_access_engine;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0, cmd_abort = 1'b0;
   logic [4:0]  cmd_first = '0, cmd_last = '0;
   logic        rf_enable_write;
   logic [4:0]  rf_write_address, rf_read_address, out_addr;
   logic [31:0] rf_write_data, rf_read_data, in_data = '0, out_data;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic        busy, done, err;
   logic [31:0] rf [32];
   int          wr_cnt = 0;
   int          n_cmp = 0, n_bad = 0;

   regfile_access_engine dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_first(cmd_first), .cmd_last(cmd_last),
      .cmd_abort(cmd_abort), .rf_enable_write(rf_enable_write),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .rf_read_address(rf_read_address), .rf_read_data(rf_read_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // behavioural register file: x0 discards writes and reads zero
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   assign rf_read_data = rf_read_address == 5'd0 ? 32'd0 : rf[rf_read_address];
   always @(posedge clk) if (rf_enable_write) begin
      wr_cnt <= wr_cnt + 1;
      if (rf_write_address != 5'd0) rf[rf_write_address] <= rf_write_data;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic mode, input int first, input int last);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_first = 5'(first);
      cmd_last  = 5'(last);
      chk("cmd_ready_idle", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_we"}, rf_enable_write, 0);
      chk({tag, "_wdata"}, rf_write_data, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // cut >= 0 asserts reset in the middle of word cut instead of writing it
   task automatic do_fill(input int first, input logic [31:0] w[$], input int cut);
      int n  = w.size();
      int w0 = wr_cnt;
      send_cmd(1'b1, first, first + n - 1);
      chk("fill_busy", busy, 1);
      for (int k = 0; k < n; k++) begin
         if (k == cut) begin
            in_valid = 1'b0;
            #2 rst = 1'b0;
            #1;
            check_idle_outputs("fill_rst");
            chk("fill_rst_ptr", rf_read_address, 0);
            chk("fill_rst_wcnt", wr_cnt - w0, cut);
            @(negedge clk);
            rst = 1'b1;
            step();
            return;
         end
         in_valid = 1'b1;
         in_data  = w[k];
         #1;
         chk("fill_in_ready", in_ready, 1);
         chk("fill_we", rf_enable_write, 1);
         chk("fill_waddr", rf_write_address, first + k);
         chk("fill_wdata", rf_write_data, w[k]);
         chk("fill_no_early_done", done, 0);
         step();
      end
      in_valid = 1'b0;
      #1;
      chk("fill_done", done, 1);
      chk("fill_done_cmd_ready", cmd_ready, 1);
      chk("fill_we_after", rf_enable_write, 0);
      chk("fill_wcnt", wr_cnt - w0, n);
      step();
      chk("fill_done_once", done, 0);
   endtask

   task automatic do_dump(input int first, input logic [31:0] d[$], input int stall_k,
                          input int stall_n, input int abort_k);
      int n   = d.size();
      int cyc = 1;
      send_cmd(1'b0, first, first + n - 1);
      chk("dump_busy", busy, 1);
      for (int k = 0; k < n; k++) begin
         chk("dump_rd_gap", out_valid, 0);
         step();
         cyc++;
         if (k == stall_k) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_addr", out_addr, first + k);
               chk("stall_data", out_data, d[k]);
               step();
               cyc++;
            end
            out_ready = 1'b1;
         end
         if (k == abort_k) begin
            out_ready = 1'b0;
            cmd_abort = 1'b1;
            chk("abort_valid_before", out_valid, 1);
            step();
            cmd_abort = 1'b0;
            out_ready = 1'b1;
            chk("abort_valid_drop", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_no_done", done, 0);
            step();
            chk("abort_no_done_late", done, 0);
            return;
         end
         chk("dump_valid", out_valid, 1);
         chk("dump_addr", out_addr, first + k);
         chk("dump_data", out_data, d[k]);
         step();
         cyc++;
      end
      chk("dump_done", done, 1);
      chk("dump_done_cmd_ready", cmd_ready, 1);
      chk("dump_cycles", cyc, 2 * n + 1 + (stall_k < n ? stall_n : 0));
      step();
      chk("dump_done_once", done, 0);
   endtask

   initial begin
      int w0;
      // test 1: asynchronous reset mid-clock
      #3 rst = 1'b0;
      #1;
      check_idle_outputs("reset");
      chk("reset_out_addr", out_addr, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_raddr", rf_read_address, 0);
      chk("reset_waddr", rf_write_address, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) step();
      check_idle_outputs("post_reset");
      // test 2 and 3: fill 5..7 then dump it back
      do_fill(5, '{32'h11111111, 32'h22222222, 32'h33333333}, -1);
      chk("rf_x5", rf[5], 32'h11111111);
      chk("rf_x6", rf[6], 32'h22222222);
      chk("rf_x7", rf[7], 32'h33333333);
      do_dump(5, '{32'h11111111, 32'h22222222, 32'h33333333}, 99, 0, 99);
      // test 4: four-cycle stall on the second word
      do_dump(5, '{32'h11111111, 32'h22222222, 32'h33333333}, 1, 4, 99);
      // test 5: x0 discard and single-word range at the top register
      do_fill(0, '{32'hDEADBEEF, 32'h00000042}, -1);
      do_dump(0, '{32'h00000000, 32'h00000042}, 99, 0, 99);
      do_fill(31, '{32'hA5A5A5A5}, -1);
      do_dump(31, '{32'hA5A5A5A5}, 99, 0, 99);
      // test 6: rejected range
      w0 = wr_cnt;
      send_cmd(1'b1, 9, 3);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_cmd_ready", cmd_ready, 1);
      chk("err_in_ready", in_ready, 0);
      step();
      chk("err_once", err, 0);
      chk("err_no_write", wr_cnt - w0, 0);
      // abort on the second dump word
      do_dump(5, '{32'h11111111, 32'h22222222, 32'h33333333}, 99, 0, 1);
      // reset after two of three fill writes
      do_fill(10, '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003}, 2);
      chk("rst_fill_x10", rf[10], 32'hCAFE0001);
      chk("rst_fill_x11", rf[11], 32'hCAFE0002);
      chk("rst_fill_x12", rf[12], 32'h00000000);
      chk("rst_fill_x7", rf[7], 32'h33333333);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
